// File: rtl/eyetracker_pkg.sv
// Shared definitions for the stereo camera capture path: capture FSM states
// and the bit positions inside the sticky geometry error word.
package eyetracker_pkg;

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ARM      = 2'd1,
        S_WAIT_SOF = 2'd2,
        S_FRAME    = 2'd3
    } cap_state_t;

    localparam int unsigned ERR_LINE_LONG   = 0;
    localparam int unsigned ERR_LINE_SHORT  = 1;
    localparam int unsigned ERR_FRAME_LONG  = 2;
    localparam int unsigned ERR_FRAME_SHORT = 3;

endpackage

// File: rtl/cam_sig_reg.sv
// Stage-1 register for the raw sensor bus, with rise/fall detection on the
// registered frame and line valids.
module cam_sig_reg #(
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   fval,
    input  logic                   lval,
    input  logic                   dval,
    input  logic [PIXEL_WIDTH-1:0] data_l,
    input  logic [PIXEL_WIDTH-1:0] data_r,
    output logic                   s1_fval,
    output logic                   s1_lval,
    output logic                   s1_dval,
    output logic [PIXEL_WIDTH-1:0] s1_data_l,
    output logic [PIXEL_WIDTH-1:0] s1_data_r,
    output logic                   fval_rise,
    output logic                   fval_fall,
    output logic                   lval_fall
);

    logic fval_d;
    logic lval_d;

    // Capture the pins and keep a one-cycle-older copy of the stage-1 valids.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_fval   <= 1'b0;
            s1_lval   <= 1'b0;
            s1_dval   <= 1'b0;
            s1_data_l <= '0;
            s1_data_r <= '0;
            fval_d    <= 1'b0;
            lval_d    <= 1'b0;
        end else begin
            s1_fval   <= fval;
            s1_lval   <= lval;
            s1_dval   <= dval;
            s1_data_l <= data_l;
            s1_data_r <= data_r;
            fval_d    <= s1_fval;
            lval_d    <= s1_lval;
        end
    end

    // Edges as seen at stage 1.
    always_comb begin
        fval_rise = s1_fval & ~fval_d;
        fval_fall = ~s1_fval & fval_d;
        lval_fall = ~s1_lval & lval_d;
    end

endmodule

// File: rtl/stereo_cam_capture.sv
// Stereo sensor capture: frame-gated arming FSM, X/Y counters cropped to the
// active window, registered pixel stream with markers, sticky geometry errors.
module stereo_cam_capture
    import eyetracker_pkg::*;
#(
    parameter int PIXEL_WIDTH = 8,
    parameter int HACTIVE     = 320,
    parameter int VACTIVE     = 480,
    parameter int XW          = 10,
    parameter int YW          = 10
) (
    input  logic                   CCLK,
    input  logic                   RST,
    input  logic                   iENABLE,
    input  logic                   iCLR_ERR,
    input  logic                   FVAL,
    input  logic                   LVAL,
    input  logic                   DVAL,
    input  logic [PIXEL_WIDTH-1:0] DATA_L,
    input  logic [PIXEL_WIDTH-1:0] DATA_R,
    output logic                   oDE,
    output logic [PIXEL_WIDTH-1:0] oDATA_L,
    output logic [PIXEL_WIDTH-1:0] oDATA_R,
    output logic [XW-1:0]          oX,
    output logic [YW-1:0]          oY,
    output logic                   oSOF,
    output logic                   oEOL,
    output logic                   oEOF,
    output logic                   oBUSY,
    output logic [15:0]            oFRAME_CNT,
    output logic [3:0]             oERR
);

    // Counters carry one extra bit and stop one past the active size, so an
    // over-long line/frame stays distinguishable from an exact one.
    localparam logic [XW:0] X_ACT  = (XW+1)'(HACTIVE);
    localparam logic [XW:0] X_LAST = (XW+1)'(HACTIVE - 1);
    localparam logic [XW:0] X_SAT  = (XW+1)'(HACTIVE + 1);
    localparam logic [YW:0] Y_ACT  = (YW+1)'(VACTIVE);
    localparam logic [YW:0] Y_SAT  = (YW+1)'(VACTIVE + 1);

    logic                   s1_fval, s1_lval, s1_dval;
    logic [PIXEL_WIDTH-1:0] s1_data_l, s1_data_r;
    logic                   fval_rise, fval_fall, lval_fall;

    cap_state_t  state, state_next;
    logic [XW:0] x, x_cur, x_next;
    logic [YW:0] y, y_cur, y_line;
    logic        frame_start, active, q, emit, line_end, frame_end;
    logic [3:0]  err_set;

    cam_sig_reg #(
        .PIXEL_WIDTH(PIXEL_WIDTH)
    ) u_sig_reg (
        .clk       (CCLK),
        .rst       (RST),
        .fval      (FVAL),
        .lval      (LVAL),
        .dval      (DVAL),
        .data_l    (DATA_L),
        .data_r    (DATA_R),
        .s1_fval   (s1_fval),
        .s1_lval   (s1_lval),
        .s1_dval   (s1_dval),
        .s1_data_l (s1_data_l),
        .s1_data_r (s1_data_r),
        .fval_rise (fval_rise),
        .fval_fall (fval_fall),
        .lval_fall (lval_fall)
    );

    // Capture state register.
    always_ff @(posedge CCLK or posedge RST) begin
        if (RST) state <= S_IDLE;
        else     state <= state_next;
    end

    // Next-state: arm only between frames, enter capture on a frame rise.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE:     if (iENABLE) state_next = S_ARM;
            S_ARM:      if (!s1_fval) state_next = S_WAIT_SOF;
            S_WAIT_SOF: begin
                if (!iENABLE)       state_next = S_IDLE;
                else if (fval_rise) state_next = S_FRAME;
            end
            S_FRAME:    if (fval_fall) state_next = iENABLE ? S_WAIT_SOF : S_IDLE;
            default:    state_next = S_IDLE;
        endcase
    end

    // Pixel qualification, counter updates and geometry checks. The cycle that
    // enters S_FRAME is treated as in-frame with counters forced to zero, so a
    // pixel arriving together with the frame rise is not lost.
    always_comb begin
        frame_start = (state == S_WAIT_SOF) && (state_next == S_FRAME);
        active      = (state == S_FRAME) || frame_start;
        x_cur       = frame_start ? '0 : x;
        y_cur       = frame_start ? '0 : y;
        q           = s1_fval & s1_lval & s1_dval;
        emit        = active && q && (x_cur < X_ACT) && (y_cur < Y_ACT);
        line_end    = active && lval_fall && (x_cur != '0);
        frame_end   = (state == S_FRAME) && fval_fall;

        x_next = x_cur;
        if (active && q && (x_cur != X_SAT)) x_next = x_cur + 1'b1;
        else if (active && lval_fall)        x_next = '0;

        y_line = y_cur;
        if (line_end && (y_cur != Y_SAT)) y_line = y_cur + 1'b1;

        err_set = '0;
        err_set[ERR_LINE_LONG]   = line_end && (x_cur > X_ACT);
        err_set[ERR_LINE_SHORT]  = line_end && (x_cur < X_ACT);
        err_set[ERR_FRAME_LONG]  = frame_end && (y_line > Y_ACT);
        err_set[ERR_FRAME_SHORT] = frame_end && (y_line < Y_ACT);
    end

    // Position counters.
    always_ff @(posedge CCLK or posedge RST) begin
        if (RST) begin
            x <= '0;
            y <= '0;
        end else begin
            x <= x_next;
            y <= y_line;
        end
    end

    // Output register, frame counter and sticky errors (a new error beats a clear).
    always_ff @(posedge CCLK or posedge RST) begin
        if (RST) begin
            oDE        <= 1'b0;
            oDATA_L    <= '0;
            oDATA_R    <= '0;
            oX         <= '0;
            oY         <= '0;
            oSOF       <= 1'b0;
            oEOL       <= 1'b0;
            oEOF       <= 1'b0;
            oFRAME_CNT <= '0;
            oERR       <= '0;
        end else begin
            oDE  <= emit;
            oSOF <= emit && (x_cur == '0) && (y_cur == '0);
            oEOL <= emit && (x_cur == X_LAST);
            oEOF <= frame_end;
            if (emit) begin
                oDATA_L <= s1_data_l;
                oDATA_R <= s1_data_r;
                oX      <= x_cur[XW-1:0];
                oY      <= y_cur[YW-1:0];
            end
            if (frame_end) oFRAME_CNT <= oFRAME_CNT + 16'd1;
            oERR <= (iCLR_ERR ? 4'b0000 : oERR) | err_set;
        end
    end

    assign oBUSY = (state == S_FRAME);

endmodule
